// File: rtl/glove_tracker_pkg.sv
// Shared widths and FSM encoding for the glove tracker and its centroid divider.
package glove_tracker_pkg;
  localparam int SUM_W  = 30;
  localparam int CNT_W  = 20;
  localparam int Q_W    = 10;
  localparam int STEP_W = 5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DX1  = 3'd1,
    S_DY1  = 3'd2,
    S_DX2  = 3'd3,
    S_DY2  = 3'd4,
    S_UPD  = 3'd5
  } state_e;
endpackage

// File: rtl/glove_tracker_seq_divider.sv
// Restoring divider, SUM_W-bit dividend by CNT_W-bit divisor, one quotient bit per cycle.
module glove_tracker_seq_divider
  import glove_tracker_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [SUM_W-1:0] dividend_i,
  input  logic [CNT_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Q_W-1:0]   quotient_o
);
  logic [SUM_W-1:0]  quo_q, quo_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [CNT_W:0]    shifted, trial;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    step_d  = step_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[SUM_W-1]};
    // borrow out of bit CNT_W means the partial remainder is below the divisor
    trial   = shifted - {1'b0, divisor_i};
    if (start_i && !busy_q) begin
      quo_d  = dividend_i;
      rem_d  = '0;
      step_d = STEP_W'(SUM_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (trial[CNT_W]) begin
        rem_d = shifted[CNT_W-1:0];
        quo_d = {quo_q[SUM_W-2:0], 1'b0};
      end else begin
        rem_d = trial[CNT_W-1:0];
        quo_d = {quo_q[SUM_W-2:0], 1'b1};
      end
      step_d = step_q - STEP_W'(1);
      if (step_q == STEP_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      step_q <= step_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q[Q_W-1:0];
endmodule

// File: rtl/glove_tracker.sv
// Per-frame glove centroid, presence and open/closed tracker fed by per-pixel colour matches.
// state  | meaning
// IDLE   | accumulating, waiting for vsync falling edge
// DX1/DY1| glove-1 centroid x / y divide (skipped when absent)
// DX2/DY2| glove-2 centroid x / y divide (skipped when absent)
// UPD    | publish all outputs together
module glove_tracker
  import glove_tracker_pkg::*;
#(
  parameter int H_ACTIVE   = 1024,
  parameter int V_ACTIVE   = 768,
  parameter int MIN_PIX    = 64,
  parameter int CLOSED_PIX = 1500
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [10:0]        hcount,
  input  logic [9:0]         vcount,
  input  logic               vsync,
  input  logic               pix_valid,
  input  logic               match1,
  input  logic               match2,
  output logic signed [10:0] rel_glove1x,
  output logic signed [9:0]  rel_glove1y,
  output logic signed [10:0] rel_glove2x,
  output logic signed [9:0]  rel_glove2y,
  output logic               glove1closed,
  output logic               glove2closed,
  output logic               present1,
  output logic               present2,
  output logic               pos_valid,
  output logic               frame_drop
);
  state_e           state_q, state_d;
  logic             vsync_q, frame_end, in_active;
  logic [1:0]       hit, present_snap;
  logic [SUM_W-1:0] sumx_q [2], sumx_d [2], sumy_q [2], sumy_d [2], snx_q [2], sny_q [2];
  logic [CNT_W-1:0] cnt_q [2], cnt_d [2], snc_q [2];
  logic [Q_W-1:0]   quo_q [4];
  logic [10:0]      relx_q [2];
  logic [9:0]       rely_q [2];
  logic [1:0]       closed_q, present_q;
  logic             pos_valid_q, frame_drop_q;
  logic             sel_glove, sel_y, sel_present;
  logic             div_start, div_busy, div_done;
  logic [Q_W-1:0]   div_quot;

  assign frame_end = vsync_q && !vsync;
  assign in_active = pix_valid && (hcount < 11'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
  assign hit       = {match2, match1} & {2{in_active}};

  // A frame-end cycle restarts the sums but still counts its own matches
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      sumx_d[g] = (frame_end ? '0 : sumx_q[g]) + (hit[g] ? SUM_W'(hcount) : '0);
      sumy_d[g] = (frame_end ? '0 : sumy_q[g]) + (hit[g] ? SUM_W'(vcount) : '0);
      cnt_d[g]  = (frame_end ? '0 : cnt_q[g]) + CNT_W'(hit[g]);
      present_snap[g] = snc_q[g] >= CNT_W'(MIN_PIX);
    end
  end

  assign sel_glove   = (state_q == S_DX2) || (state_q == S_DY2);
  assign sel_y       = (state_q == S_DY1) || (state_q == S_DY2);
  assign sel_present = present_snap[sel_glove];

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    case (state_q)
      S_IDLE: if (frame_end) state_d = S_DX1;
      S_DX1, S_DY1, S_DX2, S_DY2: begin
        if (!sel_present || div_done) state_d = state_e'(state_q + 3'd1);
        else if (!div_busy)           div_start = 1'b1;
      end
      S_UPD:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  glove_tracker_seq_divider u_div (
    .clock      (clock),
    .reset      (reset),
    .start_i    (div_start),
    .dividend_i (sel_y ? sny_q[sel_glove] : snx_q[sel_glove]),
    .divisor_i  (snc_q[sel_glove]),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vsync_q      <= 1'b1;
      pos_valid_q  <= 1'b0;
      frame_drop_q <= 1'b0;
      closed_q     <= '0;
      present_q    <= '0;
      for (int g = 0; g < 2; g++) begin
        sumx_q[g] <= '0; sumy_q[g] <= '0; cnt_q[g] <= '0;
        snx_q[g]  <= '0; sny_q[g]  <= '0; snc_q[g] <= '0;
        relx_q[g] <= '0; rely_q[g] <= '0;
      end
      for (int i = 0; i < 4; i++) quo_q[i] <= '0;
    end else begin
      vsync_q      <= vsync;
      pos_valid_q  <= (state_q == S_UPD);
      frame_drop_q <= frame_end && (state_q != S_IDLE);
      for (int g = 0; g < 2; g++) begin
        sumx_q[g] <= sumx_d[g];
        sumy_q[g] <= sumy_d[g];
        cnt_q[g]  <= cnt_d[g];
        if (frame_end && state_q == S_IDLE) begin
          snx_q[g] <= sumx_q[g];
          sny_q[g] <= sumy_q[g];
          snc_q[g] <= cnt_q[g];
        end
        if (state_q == S_UPD) begin
          present_q[g] <= present_snap[g];
          if (present_snap[g]) begin
            relx_q[g]   <= {1'b0, quo_q[2*g]} - 11'(H_ACTIVE/2);
            rely_q[g]   <= quo_q[2*g+1] - 10'(V_ACTIVE/2);
            closed_q[g] <= snc_q[g] < CNT_W'(CLOSED_PIX);
          end
        end
      end
      if (div_done) quo_q[{sel_glove, sel_y}] <= div_quot;
    end
  end

  assign rel_glove1x  = relx_q[0];
  assign rel_glove1y  = rely_q[0];
  assign rel_glove2x  = relx_q[1];
  assign rel_glove2y  = rely_q[1];
  assign glove1closed = closed_q[0];
  assign glove2closed = closed_q[1];
  assign present1     = present_q[0];
  assign present2     = present_q[1];
  assign pos_valid    = pos_valid_q;
  assign frame_drop   = frame_drop_q;
endmodule

// File: tb/tb_glove_tracker.sv
// Directed bench: full-size trackers (MIN_PIX 64 and 1) plus a 64x32 instance for whole-frame matching.
module tb_glove_tracker;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        vsync = 1'b1, pix_valid = 1'b0, match1 = 1'b0, match2 = 1'b0;

  logic signed [10:0] r1x [3], r2x [3];
  logic signed [9:0]  r1y [3], r2y [3];
  logic c1 [3], c2 [3], p1 [3], p2 [3], pv [3], fd [3];

  int pv_n [3];
  int fd_n [3];
  int n_chk = 0, n_err = 0, lat;

  always #5 clock = ~clock;

  glove_tracker u_dut (
    .clock(clock), .reset(reset), .hcount(hcount), .vcount(vcount), .vsync(vsync),
    .pix_valid(pix_valid), .match1(match1), .match2(match2),
    .rel_glove1x(r1x[0]), .rel_glove1y(r1y[0]), .rel_glove2x(r2x[0]), .rel_glove2y(r2y[0]),
    .glove1closed(c1[0]), .glove2closed(c2[0]), .present1(p1[0]), .present2(p2[0]),
    .pos_valid(pv[0]), .frame_drop(fd[0]));

  glove_tracker #(.MIN_PIX(1)) u_min1 (
    .clock(clock), .reset(reset), .hcount(hcount), .vcount(vcount), .vsync(vsync),
    .pix_valid(pix_valid), .match1(match1), .match2(match2),
    .rel_glove1x(r1x[1]), .rel_glove1y(r1y[1]), .rel_glove2x(r2x[1]), .rel_glove2y(r2y[1]),
    .glove1closed(c1[1]), .glove2closed(c2[1]), .present1(p1[1]), .present2(p2[1]),
    .pos_valid(pv[1]), .frame_drop(fd[1]));

  glove_tracker #(.H_ACTIVE(64), .V_ACTIVE(32)) u_small (
    .clock(clock), .reset(reset), .hcount(hcount), .vcount(vcount), .vsync(vsync),
    .pix_valid(pix_valid), .match1(match1), .match2(match2),
    .rel_glove1x(r1x[2]), .rel_glove1y(r1y[2]), .rel_glove2x(r2x[2]), .rel_glove2y(r2y[2]),
    .glove1closed(c1[2]), .glove2closed(c2[2]), .present1(p1[2]), .present2(p2[2]),
    .pos_valid(pv[2]), .frame_drop(fd[2]));

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      if (pv[i]) pv_n[i]++;
      if (fd[i]) fd_n[i]++;
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 3; i++) begin
      pv_n[i] = 0;
      fd_n[i] = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      pix_valid = 1'b0; match1 = 1'b0; match2 = 1'b0;
    end
  endtask

  task automatic pix(input int x, input int y, input logic m1, input logic m2);
    tick();
    hcount = 11'(x); vcount = 10'(y);
    pix_valid = 1'b1; match1 = m1; match2 = m2;
  endtask

  task automatic blk(input int x0, input int y0, input int w, input int h,
                     input logic m1, input logic m2);
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++) pix(x, y, m1, m2);
  endtask

  task automatic vfall();
    idle(1);
    vsync = 1'b0;
    idle(2);
    vsync = 1'b1;
  endtask

  task automatic end_frame();
    clr();
    vfall();
    idle(200);
  endtask

  initial begin
    clr();
    idle(3);
    chk("rst_r1x", r1x[0], 0);
    chk("rst_p1", p1[0], 0);
    chk("rst_c2", c2[1], 0);
    chk("rst_pv", pv[0], 0);
    reset = 1'b0;
    idle(3);

    // single pixel, MIN_PIX=1 instance reports it, default instance does not
    pix(100, 200, 1'b1, 1'b0);
    end_frame();
    chk("t1_pv", pv_n[1], 1);
    chk("t1_r1x", r1x[1], -412);
    chk("t1_r1y", r1y[1], -184);
    chk("t1_p1", p1[1], 1);
    chk("t1_c1", c1[1], 1);
    chk("t1_p2", p2[1], 0);
    chk("t1_dut_pv", pv_n[0], 1);
    chk("t1_dut_p1", p1[0], 0);

    blk(300, 400, 10, 10, 1'b0, 1'b1);
    end_frame();
    chk("t2_r2x", r2x[0], -208);
    chk("t2_r2y", r2y[0], 20);
    chk("t2_p2", p2[0], 1);
    chk("t2_c2", c2[0], 1);
    chk("t2_p1", p1[0], 0);

    blk(200, 100, 40, 50, 1'b1, 1'b0);
    end_frame();
    chk("t3a_p1", p1[0], 1);
    chk("t3a_c1", c1[0], 0);
    chk("t3a_r1x", r1x[0], -293);
    chk("t3a_r1y", r1y[0], -260);
    chk("t3a_p2", p2[0], 0);
    chk("t3a_r2x_hold", r2x[0], -208);

    blk(600, 700, 30, 1, 1'b1, 1'b0);
    end_frame();
    chk("t3b_p1", p1[0], 0);
    chk("t3b_r1x_hold", r1x[0], -293);
    chk("t3b_r1y_hold", r1y[0], -260);
    chk("t3b_c1_hold", c1[0], 0);
    chk("t3b_min1_r1x", r1x[1], 102);

    // every pixel of the small frame matches both gloves; also measure frame-end latency
    blk(0, 0, 64, 32, 1'b1, 1'b1);
    clr();
    idle(1);
    vsync = 1'b0;
    lat = 0;
    while (pv[2] !== 1'b1 && lat < 300) begin
      idle(1);
      lat++;
      if (lat == 2) vsync = 1'b1;
    end
    chk("t4_lat_le_130", int'(lat <= 130), 1);
    idle(100);
    chk("t4_r1x", r1x[2], -1);
    chk("t4_r1y", r1y[2], -1);
    chk("t4_r2x", r2x[2], -1);
    chk("t4_r2y", r2y[2], -1);
    chk("t4_p1", p1[2], 1);
    chk("t4_p2", p2[2], 1);
    chk("t4_c1", c1[2], 0);

    // second frame end while dividing: dropped, junk between the edges discarded
    blk(0, 0, 10, 10, 1'b1, 1'b0);
    clr();
    vfall();
    for (int i = 0; i < 15; i++) pix(1023, 767, 1'b1, 1'b0);
    idle(2);
    vfall();
    idle(200);
    chk("t5_fd", fd_n[0], 1);
    chk("t5_pv", pv_n[0], 1);
    chk("t5_r1x", r1x[0], -508);
    chk("t5_r1y", r1y[0], -380);
    blk(1000, 760, 10, 8, 1'b1, 1'b0);
    end_frame();
    chk("t5n_r1x", r1x[0], 492);
    chk("t5n_r1y", r1y[0], 379);
    chk("t5n_c1", c1[0], 1);
    chk("t5n_fd", fd_n[0], 0);

    // reset while the divider is busy on glove-1 y
    blk(300, 300, 10, 10, 1'b1, 1'b0);
    clr();
    vfall();
    idle(45);
    reset = 1'b1;
    #1;
    chk("t6_rst_r1x", r1x[0], 0);
    chk("t6_rst_p1", p1[0], 0);
    chk("t6_rst_c1", c1[0], 0);
    idle(3);
    reset = 1'b0;
    idle(200);
    chk("t6_no_pv", pv_n[0], 0);
    blk(300, 300, 10, 10, 1'b1, 1'b0);
    end_frame();
    chk("t6n_pv", pv_n[0], 1);
    chk("t6n_r1x", r1x[0], -208);
    chk("t6n_r1y", r1y[0], -80);
    chk("t6n_p1", p1[0], 1);
    chk("t6n_c1", c1[0], 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
